// File: rtl/query_patch_bank_buffer_if.sv
// Loader/compute-side bundle for query_patch_bank_buffer.
// The master modport drives loads and read requests; the slave modport is the buffer.
interface query_patch_bank_buffer_if #(
  parameter int unsigned PATCH_W    = 55,
  parameter int unsigned ADDR_WIDTH = 9
) ();
  logic                  load_start;
  logic                  load_end;
  logic                  wvalid;
  logic                  wready;
  logic [PATCH_W-1:0]    wpatch;
  logic                  load_done;
  logic [ADDR_WIDTH:0]   patch_count;
  logic                  rreq;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rvalid;
  logic [PATCH_W-1:0]    rpatch;
  logic                  rerr;

  modport master (
    output load_start, load_end, wvalid, wpatch, rreq, raddr,
    input  wready, load_done, patch_count, rvalid, rpatch, rerr
  );

  modport slave (
    input  load_start, load_end, wvalid, wpatch, rreq, raddr,
    output wready, load_done, patch_count, rvalid, rpatch, rerr
  );
endinterface

// File: rtl/query_patch_bank_buffer.sv
// Multi-bank query-patch store on 1rw1r SRAM macros: sequential loads, 1-cycle random reads.
// Optional per-patch even parity is enabled with `define QPB_PARITY_EN.
module query_patch_bank_buffer #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned PATCH_SIZE  = 5,
  parameter int unsigned MACRO_WIDTH = 32,
  parameter int unsigned BANK_DEPTH  = 256,
  parameter int unsigned NUM_BANKS   = 2
) (
  input logic                      clk,
  input logic                      rst,
  query_patch_bank_buffer_if.slave bus
);
  localparam int unsigned W          = DATA_WIDTH * PATCH_SIZE;
  localparam int unsigned DEPTH      = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CW         = ADDR_WIDTH + 1;
  localparam int unsigned ROW_W      = $clog2(BANK_DEPTH);
  localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
`ifdef QPB_PARITY_EN
  localparam int unsigned PAR_W      = 1;
`else
  localparam int unsigned PAR_W      = 0;
`endif
  // Parity lives in the first pad bit; an exact fit therefore gains one macro column.
  localparam int unsigned SLICES     = (W + PAR_W + MACRO_WIDTH - 1) / MACRO_WIDTH;
  localparam int unsigned PW         = SLICES * MACRO_WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rvalid_q, roor_q;
  logic [BANK_W-1:0]     rbank_q;
  logic [W-1:0]          hold_q;

  logic                  wready, wr_fire;
  logic                  rd_acc, rd_oor, rd_mem;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [BANK_W-1:0]     wbank, rbank;
  logic [ROW_W-1:0]      wrow, rrow;
  logic [PW-1:0]         wdata;
  logic [PW-1:0]         bank_dout [NUM_BANKS];
  logic [PW-1:0]         sel_word;
  logic [W-1:0]          rpatch;

  function automatic logic [BANK_W-1:0] bank_of(logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] s;
    s = a >> ROW_W;
    return s[BANK_W-1:0];
  endfunction

  // A load_start cycle never accepts a beat, whatever state we are in.
  assign wready  = (state_q == StLoad) && (count_q < CW'(DEPTH)) && !bus.load_start;
  assign wr_fire = bus.wvalid && wready;
  assign waddr   = count_q[ADDR_WIDTH-1:0];
  assign wbank   = bank_of(waddr);
  assign wrow    = waddr[ROW_W-1:0];

  assign rd_acc  = bus.rreq && (state_q == StReady);
  assign rd_oor  = {1'b0, bus.raddr} >= count_q;
  assign rd_mem  = rd_acc && !rd_oor;
  assign rbank   = bank_of(bus.raddr);
  assign rrow    = bus.raddr[ROW_W-1:0];

  always_comb begin
    wdata = '0;
    wdata[W-1:0] = bus.wpatch;
`ifdef QPB_PARITY_EN
    wdata[W] = ^bus.wpatch;
`endif
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StLoad: begin
        if (wr_fire) count_d = count_q + CW'(1);
        if (bus.load_end || (count_q == CW'(DEPTH))) state_d = StReady;
      end
      StIdle, StReady: ;
      default: state_d = StIdle;
    endcase
    if (bus.load_start) begin
      state_d = StLoad;
      count_d = '0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic csb0, web0, csb1;
    assign csb0 = ~(wr_fire && (wbank == BANK_W'(b)));
    assign web0 = csb0;
    assign csb1 = ~(rd_mem && (rbank == BANK_W'(b)));

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
      logic [MACRO_WIDTH-1:0] mem [BANK_DEPTH];
      logic [MACRO_WIDTH-1:0] dout;
      logic [MACRO_WIDTH-1:0] wmask;
      assign wmask = '1;

      always_ff @(posedge clk) begin
        if (!csb0 && !web0) begin
          mem[wrow] <= (mem[wrow] & ~wmask) | (wdata[s*MACRO_WIDTH +: MACRO_WIDTH] & wmask);
        end
        if (!csb1) dout <= mem[rrow];
      end

      assign bank_dout[b][s*MACRO_WIDTH +: MACRO_WIDTH] = dout;
    end
  end

  assign sel_word = bank_dout[rbank_q];
  assign rpatch   = rvalid_q ? (roor_q ? '0 : sel_word[W-1:0]) : hold_q;

  if (PW > W + PAR_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^sel_word[PW-1:W+PAR_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      roor_q   <= 1'b0;
      rbank_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        roor_q  <= rd_oor;
        rbank_q <= rbank;
      end
      if (rvalid_q) hold_q <= rpatch;
    end
  end

  assign bus.wready      = wready;
  assign bus.load_done   = (state_q == StReady);
  assign bus.patch_count = count_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rpatch      = rpatch;
`ifdef QPB_PARITY_EN
  assign bus.rerr        = rvalid_q && !roor_q && (^sel_word[W:0]);
`else
  assign bus.rerr        = 1'b0;
`endif
endmodule

// File: tb/tb_query_patch_bank_buffer.sv
// Directed bench for query_patch_bank_buffer: reset, full/early loads, read vector tables.
// With QPB_PARITY_EN defined it also flips a stored bit to exercise rerr.
module tb_query_patch_bank_buffer;
  localparam int unsigned W  = 55;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  query_patch_bank_buffer_if #(.PATCH_W(W), .ADDR_WIDTH(AW)) bus ();

  query_patch_bank_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rreq;
    logic [AW-1:0] raddr;
    logic          exp_rvalid;
    logic [W-1:0]  exp_rpatch;
    logic          exp_rerr;
  } rd_vec_t;

  rd_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] early_pat(int i);
    logic [W-1:0] base;
    base = 55'h7FF;
    return (base << 44) | W'(i);
  endfunction

  // Each row drives one cycle; the result of that row's request is visible right after the edge.
  task automatic apply_vecs(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.rreq  = vecs[i].rreq;
      bus.raddr = vecs[i].raddr;
      tick();
      check($sformatf("vec%0d rvalid", i), 64'(bus.rvalid), 64'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d rpatch", i), 64'(bus.rpatch), 64'(vecs[i].exp_rpatch));
      check($sformatf("vec%0d rerr", i), 64'(bus.rerr), 64'(vecs[i].exp_rerr));
    end
    bus.rreq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // After the full load (patch i = 3*i): back-to-back reads across the bank boundary.
    vecs[0]  = '{1'b1, 9'd300, 1'b1, W'(900),  1'b0};
    vecs[1]  = '{1'b1, 9'd255, 1'b1, W'(765),  1'b0};
    vecs[2]  = '{1'b1, 9'd256, 1'b1, W'(768),  1'b0};
    vecs[3]  = '{1'b1, 9'd0,   1'b1, W'(0),    1'b0};
    vecs[4]  = '{1'b1, 9'd511, 1'b1, W'(1533), 1'b0};
    vecs[5]  = '{1'b0, 9'd17,  1'b0, W'(1533), 1'b0};
    vecs[6]  = '{1'b0, 9'd0,   1'b0, W'(1533), 1'b0};
    // After the early-ended 10-patch load.
    vecs[7]  = '{1'b1, 9'd9,   1'b1, early_pat(9), 1'b0};
    vecs[8]  = '{1'b1, 9'd10,  1'b1, W'(0),        1'b0};
    vecs[9]  = '{1'b1, 9'd3,   1'b1, early_pat(3), 1'b0};
    vecs[10] = '{1'b1, 9'd300, 1'b1, W'(0),        1'b0};
    vecs[11] = '{1'b0, 9'd0,   1'b0, W'(0),        1'b0};

    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    bus.wvalid     = 1'b0;
    bus.wpatch     = '0;
    bus.rreq       = 1'b0;
    bus.raddr      = '0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset wready", 64'(bus.wready), 64'd0);
    check("reset load_done", 64'(bus.load_done), 64'd0);
    check("reset patch_count", 64'(bus.patch_count), 64'd0);
    check("reset rvalid", 64'(bus.rvalid), 64'd0);
    check("reset rpatch", 64'(bus.rpatch), 64'd0);
    check("reset rerr", 64'(bus.rerr), 64'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a load.
    bus.load_start = 1'b1;
    bus.wvalid     = 1'b1;
    tick();
    check("load_start beat refused", 64'(bus.patch_count), 64'd0);
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wpatch = W'(i);
      tick();
    end
    check("mid-load count", 64'(bus.patch_count), 64'd3);
    rst = 1'b1;
    #1;
    check("async rst patch_count", 64'(bus.patch_count), 64'd0);
    check("async rst wready", 64'(bus.wready), 64'd0);
    check("async rst load_done", 64'(bus.load_done), 64'd0);
    bus.wvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("idle wready", 64'(bus.wready), 64'd0);
    check("idle load_done", 64'(bus.load_done), 64'd0);
    bus.rreq = 1'b1;
    tick();
    bus.rreq = 1'b0;
    check("idle rreq ignored", 64'(bus.rvalid), 64'd0);

    // Full load, with one ignored read request while loading.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.rreq  = 1'b1;
    bus.raddr = 9'd0;
    tick();
    bus.rreq = 1'b0;
    check("load rreq ignored", 64'(bus.rvalid), 64'd0);
    for (int i = 0; i < 512; i++) begin
      bus.wvalid = 1'b1;
      bus.wpatch = W'(i * 3);
      #1;
      check($sformatf("wready beat %0d", i), 64'(bus.wready), 64'd1);
      tick();
    end
    check("full count", 64'(bus.patch_count), 64'd512);
    check("full wready low", 64'(bus.wready), 64'd0);
    tick();
    bus.wvalid = 1'b0;
    check("full load_done", 64'(bus.load_done), 64'd1);
    check("full count held", 64'(bus.patch_count), 64'd512);
    apply_vecs(0, 6);

    // Read coincident with load_start completes with old data.
    bus.load_start = 1'b1;
    bus.rreq       = 1'b1;
    bus.raddr      = 9'd5;
    tick();
    bus.load_start = 1'b0;
    bus.rreq       = 1'b0;
    check("restart rvalid", 64'(bus.rvalid), 64'd1);
    check("restart rpatch", 64'(bus.rpatch), 64'd15);
    check("restart count", 64'(bus.patch_count), 64'd0);
    check("restart load_done", 64'(bus.load_done), 64'd0);
    tick();
    check("restart rvalid drop", 64'(bus.rvalid), 64'd0);
    check("restart rpatch hold", 64'(bus.rpatch), 64'd15);

    // Early end on the tenth beat.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.wvalid   = 1'b1;
      bus.wpatch   = early_pat(i);
      bus.load_end = (i == 9);
      tick();
    end
    bus.wvalid   = 1'b0;
    bus.load_end = 1'b0;
    check("early count", 64'(bus.patch_count), 64'd10);
    check("early load_done", 64'(bus.load_done), 64'd1);
    check("early wready", 64'(bus.wready), 64'd0);
    apply_vecs(7, 11);

`ifdef QPB_PARITY_EN
    dut.g_bank[0].g_slice[0].mem[7][0] = ~dut.g_bank[0].g_slice[0].mem[7][0];
    bus.rreq  = 1'b1;
    bus.raddr = 9'd7;
    tick();
    check("parity flip rerr", 64'(bus.rerr), 64'd1);
    check("parity flip rvalid", 64'(bus.rvalid), 64'd1);
    bus.raddr = 9'd6;
    tick();
    check("parity clean rerr", 64'(bus.rerr), 64'd0);
    check("parity clean rpatch", 64'(bus.rpatch), 64'(early_pat(6)));
    bus.rreq = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/query_patch_bank_buffer.md
Name: query_patch_bank_buffer

Overview:
Parametrised, multi-bank query-patch store built from 1rw1r SRAM macros. Accepts a stream of query patches from the I/O loader through a valid/ready handshake. Places each patch at an internally generated sequential address. Serves random-address reads to the compute datapath with a fixed one-cycle latency. Bank count, macro width and bank depth are generic. Bank select for read data is registered so it aligns with macro output timing.

Parameters:
DATA_WIDTH, 11, bits per patch element
PATCH_SIZE, 5, elements per patch; patch width W = DATA_WIDTH*PATCH_SIZE
MACRO_WIDTH, 32, data width of one SRAM macro
BANK_DEPTH, 256, rows per macro (power of two)
NUM_BANKS, 2, number of banks (power of two, >=1)
DEPTH, NUM_BANKS*BANK_DEPTH, total patch capacity (derived)
ADDR_WIDTH, $clog2(DEPTH), patch address width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
load_start  in  1  pulse: begin new load, clear write pointer
load_end  in  1  pulse: terminate load early
wvalid  in  1  write patch valid
wready  out  1  write patch accepted when wvalid&wready
wpatch  in  W  patch to store
load_done  out  1  high while in READY
patch_count  out  ADDR_WIDTH+1  number of patches stored in current load
rreq  in  1  read request
raddr  in  ADDR_WIDTH  read patch address
rvalid  out  1  read data valid
rpatch  out  W  read patch data
rerr  out  1  parity error on current rpatch (see Optional Feature)

Behaviour:
- Reset (async, any time): state IDLE; wready, load_done, rvalid, rerr = 0; patch_count = 0; rpatch = 0. SRAM contents are undefined after reset.
- Bank mapping:
  - bank = addr[ADDR_WIDTH-1 : log2(BANK_DEPTH)]; row = addr[log2(BANK_DEPTH)-1 : 0].
  - With NUM_BANKS=1, bank is always 0.
- Slicing:
  - Each bank is S = ceil(W/MACRO_WIDTH) macros side by side.
  - wpatch is zero-padded to S*MACRO_WIDTH; pad bits are discarded on read.
  - Macro wmask is all ones.
  - Chip select and write enable are active-low, asserted only for the addressed bank.
- FSM states IDLE, LOAD, READY:
  - IDLE: load_start -> LOAD.
  - LOAD:
    - wready = (patch_count < DEPTH).
    - Each accepted beat writes wpatch at address patch_count, then patch_count increments.
    - Transitions to READY the cycle after patch_count reaches DEPTH, or on load_end.
    - If load_end coincides with an accepted beat, the beat is written and counted, then the FSM goes to READY.
  - READY:
    - load_done = 1; wready = 0.
    - load_start -> LOAD with patch_count cleared to 0.
  - load_start in any state clears patch_count and enters LOAD. A wvalid in the same cycle is not accepted.
- Reads:
  - Accepted only in READY.
  - rreq at cycle N -> rvalid = 1 at N+1 with rpatch = stored patch.
  - Back-to-back requests give one result per cycle.
  - Bank index and an out-of-range flag are registered at N and select the macro outputs at N+1.
  - raddr >= patch_count: rvalid = 1, rpatch = 0, no macro access.
  - rreq outside READY is ignored (rvalid = 0).
  - A read accepted in the same cycle as load_start still completes at N+1.
  - rvalid deasserts the cycle after the last rreq.
  - rpatch holds its last value when rvalid = 0.
- Write and read never target the same row concurrently, because they are separated by FSM state.

Optional Feature:
QPB_PARITY_EN
- Defined:
  - One even-parity bit per stored patch, computed over wpatch and placed in the first pad bit.
  - If W is an exact multiple of MACRO_WIDTH, one extra macro column is added.
  - On read, parity is recomputed; rerr = 1 with rvalid when it mismatches.
  - Out-of-range reads give rerr = 0.
- Undefined: no parity bit is stored; rerr is tied to 0.

Test Plan:
- Reset mid-load: assert rst after 3 accepted beats -> patch_count=0, wready=0, load_done=0 immediately (async); after release, state is IDLE.
- Full load: load_start, 512 beats with wpatch=addr*3 -> wready drops after beat 511, load_done=1, patch_count=512; read raddr=300 -> rvalid next cycle, rpatch=900 (exercises bank 1).
- Early end: load_start, 10 beats with patch 0x7FF_i, load_end on the 10th beat -> patch_count=10, load_done=1; read raddr=9 -> rpatch=pattern 9; read raddr=10 -> rvalid=1, rpatch=0.
- Back-to-back reads: rreq on 4 consecutive cycles, addresses 255,256,0,511 across a bank boundary -> four consecutive rvalid cycles with matching data, no bubble or misaligned bank.
- Reads outside READY: rreq during LOAD -> rvalid stays 0; load_start in READY with coincident rreq raddr=5 -> rvalid next cycle with old patch 5, patch_count=0.
- QPB_PARITY_EN: force one macro bit flip at row 7 via backdoor -> read raddr=7 gives rerr=1; clean rows give rerr=0.
